// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - registered parametrised ALU with valid/ready handshakes and serial shifter
module alu_seq_param #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic             accept, is_shift, shift_start, shift_last;
   logic [SHW-1:0]   amt, sh_cnt;
   logic [WIDTH-1:0] sh_val, sh_next, op_res;
   logic             sh_left, sh_out, op_c, op_v;
   logic [WIDTH:0]   sum, diff;

   assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
   assign accept      = in_valid && in_ready;
   assign amt         = b[SHW-1:0];
   assign is_shift    = opcode[2] & opcode[1];
   assign shift_start = accept && is_shift && (amt != '0);
   assign shift_last  = (state == SHIFT) && (sh_cnt == SHW'(1));

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   // One bit per cycle; sh_out is the bit leaving the register on this step
   assign sh_next = sh_left ? {sh_val[WIDTH-2:0], 1'b0} : {1'b0, sh_val[WIDTH-1:1]};
   assign sh_out  = sh_left ? sh_val[WIDTH-1] : sh_val[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (shift_start) state_nxt = SHIFT;
         SHIFT:   if (shift_last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Single-cycle result path; shifts reaching here have a zero amount
   always_comb begin
      op_res = a;
      op_c   = 1'b0;
      op_v   = 1'b0;
      case (opcode)
         OP_ADD: begin
            op_res = sum[WIDTH-1:0];
            op_c   = sum[WIDTH];
            op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            op_res = diff[WIDTH-1:0];
            op_c   = diff[WIDTH];
            op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  op_res = a & b;
         OP_OR:   op_res = a | b;
         OP_XOR:  op_res = a ^ b;
         OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: op_res = a;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         negative  <= 1'b0;
         overflow  <= 1'b0;
         sh_val    <= '0;
         sh_cnt    <= '0;
         sh_left   <= 1'b0;
      end else if (accept) begin
         if (shift_start) begin
            sh_val    <= a;
            sh_cnt    <= amt;
            sh_left   <= ~opcode[0];
            out_valid <= 1'b0;
         end else begin
            result    <= op_res;
            zero      <= (op_res == '0);
            carry     <= op_c;
            negative  <= op_res[WIDTH-1];
            overflow  <= op_v;
            out_valid <= 1'b1;
         end
      end else if (state == SHIFT) begin
         sh_val <= sh_next;
         sh_cnt <= sh_cnt - SHW'(1);
         // Result is published only on the final step
         if (shift_last) begin
            result    <= sh_next;
            zero      <= (sh_next == '0);
            carry     <= sh_out;
            negative  <= sh_next[WIDTH-1];
            overflow  <= 1'b0;
            out_valid <= 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - directed bench with transaction-level model for alu_seq_param
module tb_alu_seq_param;

   logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, result;
   logic [2:0] opcode;
   logic       zero, carry, negative, overflow;

   int checks = 0;
   int errors = 0;

   int         m_busy = 0;
   bit         m_valid = 0;
   logic [9:0] m_out = '0;
   logic [9:0] m_pend = '0;

   alu_seq_param #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .carry(carry), .negative(negative), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Whole-operation arithmetic: returns {carry, overflow, result}
   function automatic logic [9:0] model_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      int         t, s;
      logic [7:0] r;
      bit         c, v;
      s = int'(y[2:0]);
      c = 0;
      v = 0;
      r = x;
      case (op)
         3'd0: begin
            t = int'(x) + int'(y);
            r = t[7:0];
            c = (t > 255);
            v = (x[7] == y[7]) && (r[7] != x[7]);
         end
         3'd1: begin
            t = int'(x) - int'(y);
            r = t[7:0];
            c = (x < y);
            v = (x[7] != y[7]) && (r[7] != x[7]);
         end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: r = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
         3'd6: begin
            t = int'(x) << s;
            r = t[7:0];
            if (s > 0) begin t = int'(x) >> (8 - s); c = t[0]; end
         end
         default: begin
            r = x >> s;
            if (s > 0) begin t = int'(x) >> (s - 1); c = t[0]; end
         end
      endcase
      return {c, v, r};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  = 0;
         m_valid = 0;
      end else if (in_valid && m_busy == 0 && (!m_valid || out_ready)) begin
         if (opcode[2:1] == 2'b11 && b[2:0] != 3'd0) begin
            m_busy  = int'(b[2:0]);
            m_pend  = model_op(opcode, a, b);
            m_valid = 0;
         end else begin
            m_out   = model_op(opcode, a, b);
            m_valid = 1;
         end
      end else if (m_busy > 0) begin
         m_busy = m_busy - 1;
         if (m_busy == 0) begin
            m_out   = m_pend;
            m_valid = 1;
         end
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, (m_busy == 0) && (!m_valid || out_ready));
      chk("out_valid", out_valid, m_valid);
      if (!rst_n)
         chk("reset_outs", {result, zero, carry, negative, overflow}, 0);
      else if (m_valid)
         chk("result_flags", {result, zero, carry, negative, overflow},
             {m_out[7:0], m_out[7:0] == 8'h00, m_out[9], m_out[7], m_out[8]});
   end

   task automatic do_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      bit ok;
      ok       = 0;
      opcode   = op;
      a        = x;
      b        = y;
      in_valid = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      chk("accept_timeout", ok, 1);
      @(posedge clk);
      #2 in_valid = 0;
   endtask

   task automatic op_check(input string nm, input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] er, input bit ez, input bit ec, input bit en, input bit ev,
                           input int elat, input int elow);
      int lat, low;
      lat = 0;
      low = 0;
      do_op(op, x, y);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (!in_ready) low++;
      end
      chk({nm, "_res"}, {result, zero, carry, negative, overflow}, {er, ez, ec, en, ev});
      chk({nm, "_lat"}, lat, elat);
      chk({nm, "_busy"}, low, elow);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 0; rst_n = 0; in_valid = 0; a = 0; b = 0; opcode = 0; out_ready = 1;
      #12;
      chk("reset_lit", {out_valid, result, zero, carry, negative, overflow}, 0);
      rst_n = 1;
      @(posedge clk);
      #2;

      op_check("add_ff_01",  3'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 1, 0);
      op_check("sub_80_01",  3'd1, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, 1, 0);
      op_check("sub_01_02",  3'd1, 8'h01, 8'h02, 8'hFF, 0, 1, 1, 0, 1, 0);
      op_check("shl_81_3",   3'd6, 8'h81, 8'h03, 8'h08, 0, 0, 0, 0, 4, 3);
      op_check("shr_81_1",   3'd7, 8'h81, 8'h01, 8'h40, 0, 1, 0, 0, 2, 1);
      op_check("shl_9c_0",   3'd6, 8'h9C, 8'h00, 8'h9C, 0, 0, 1, 0, 1, 0);
      op_check("slt_fe_01",  3'd5, 8'hFE, 8'h01, 8'h01, 0, 0, 0, 0, 1, 0);
      op_check("slt_01_fe",  3'd5, 8'h01, 8'hFE, 8'h00, 1, 0, 0, 0, 1, 0);
      op_check("and_a5_0f",  3'd2, 8'hA5, 8'h0F, 8'h05, 0, 0, 0, 0, 1, 0);
      op_check("add_7f_01",  3'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 1, 0);
      op_check("shr_80_0f",  3'd7, 8'h80, 8'h0F, 8'h01, 0, 0, 0, 0, 8, 7);
      op_check("shl_ff_7",   3'd6, 8'hFF, 8'h07, 8'h80, 0, 1, 1, 0, 8, 7);

      // Backpressure hold followed by back-to-back OR
      out_ready = 0;
      do_op(3'd4, 8'hF0, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_hold_res", {out_valid, result}, {1'b1, 8'h0F});
         chk("bp_hold_rdy", in_ready, 0);
      end
      @(posedge clk);
      #2;
      out_ready = 1; in_valid = 1; opcode = 3'd3; a = 8'h01; b = 8'h02;
      @(negedge clk);
      chk("b2b_rdy", in_ready, 1);
      @(posedge clk);
      #2 in_valid = 0;
      @(negedge clk);
      chk("b2b_res", {out_valid, result}, {1'b1, 8'h03});
      @(posedge clk);
      #2;

      // Reset during a long shift
      op_check("add_10_20",  3'd0, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0, 1, 0);
      do_op(3'd6, 8'h33, 8'h07);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("midshift_rst", {out_valid, result, zero, carry, negative, overflow}, 0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1;
      @(negedge clk);
      chk("post_rst", {in_ready, out_valid}, 2'b10);
      @(posedge clk);
      #2;
      op_check("add_02_03",  3'd0, 8'h02, 8'h03, 8'h05, 0, 0, 0, 0, 1, 0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
